// File: rtl/uart_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : uart_mmio
//  Purpose  : Memory-mapped UART responder. Decodes word loads/stores from the
//             data-memory port into four registers (TXDATA, RXDATA, STATUS,
//             CTRL), buffers TX bytes toward the uart AXI-stream sink and RX
//             bytes from its AXI-stream source, and keeps sticky error flags.
//  Ports    : clk, rst                         - clock, sync active-high reset
//             req_valid/we/addr/wdata          - request from memory stage
//             rsp_valid, rsp_rdata             - registered load response
//             m_axis_tdata/tvalid/tready       - TX byte stream to uart
//             s_axis_tdata/tvalid/tready       - RX byte stream from uart
//             tx_busy, rx_overrun_error,
//             rx_frame_error                   - uart status inputs
//  Revision : 1.0 - initial release
// ============================================================================
module uart_mmio #(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [3:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        tx_busy,
    input  logic        rx_overrun_error,
    input  logic        rx_frame_error
);

    localparam int c_TX_PW = $clog2(TX_DEPTH);
    localparam int c_TX_CW = c_TX_PW + 1;
    localparam int c_RX_PW = $clog2(RX_DEPTH);
    localparam int c_RX_CW = c_RX_PW + 1;

    localparam logic [c_TX_CW-1:0] c_TX_FULL_CNT = c_TX_CW'(TX_DEPTH);
    localparam logic [c_RX_CW-1:0] c_RX_FULL_CNT = c_RX_CW'(RX_DEPTH);
    localparam logic [c_TX_PW-1:0] c_TX_PTR_ONE  = c_TX_PW'(1);
    localparam logic [c_RX_PW-1:0] c_RX_PTR_ONE  = c_RX_PW'(1);
    localparam logic [c_TX_CW-1:0] c_TX_CNT_ONE  = c_TX_CW'(1);
    localparam logic [c_RX_CW-1:0] c_RX_CNT_ONE  = c_RX_CW'(1);

    localparam logic [1:0] c_REG_TXDATA = 2'd0;
    localparam logic [1:0] c_REG_RXDATA = 2'd1;
    localparam logic [1:0] c_REG_STATUS = 2'd2;
    localparam logic [1:0] c_REG_CTRL   = 2'd3;

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    logic [1:0] w_sel;
    logic       w_tx_wr;
    logic       w_rx_rd;
    logic       w_ctrl_wr;
    logic       w_sticky_clr;
    logic       w_rx_flush;
    logic       w_unused_bits;

    assign w_sel         = req_addr[3:2];
    assign w_tx_wr       = req_valid &&  req_we && (w_sel == c_REG_TXDATA);
    assign w_rx_rd       = req_valid && !req_we && (w_sel == c_REG_RXDATA);
    assign w_ctrl_wr     = req_valid &&  req_we && (w_sel == c_REG_CTRL);
    assign w_sticky_clr  = w_ctrl_wr && req_wdata[0];
    assign w_rx_flush    = w_ctrl_wr && req_wdata[1];
    // Byte-lane bits and upper store data carry no meaning for this block.
    assign w_unused_bits = ^{req_addr[1:0], req_wdata[31:8]};

    // ------------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------------
    logic [7:0]         r_tx_mem [TX_DEPTH];
    logic [c_TX_PW-1:0] r_tx_wptr;
    logic [c_TX_PW-1:0] r_tx_rptr;
    logic [c_TX_CW-1:0] r_tx_count;
    logic               w_tx_full;
    logic               w_tx_empty;
    logic               w_tx_push;
    logic               w_tx_pop;

    assign w_tx_full  = (r_tx_count == c_TX_FULL_CNT);
    assign w_tx_empty = (r_tx_count == '0);
    // A push to a full FIFO is rejected even when a pop frees a slot this cycle.
    assign w_tx_push  = w_tx_wr && !w_tx_full;
    assign w_tx_pop   = m_axis_tvalid && m_axis_tready;

    assign m_axis_tvalid = !w_tx_empty;
    // Stale storage is masked so nothing leaks onto the bus after reset.
    assign m_axis_tdata  = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rptr];

    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr] <= req_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + c_TX_PTR_ONE;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + c_TX_PTR_ONE;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + c_TX_CNT_ONE;
                2'b01:   r_tx_count <= r_tx_count - c_TX_CNT_ONE;
                default: r_tx_count <= r_tx_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------------
    logic [7:0]         r_rx_mem [RX_DEPTH];
    logic [c_RX_PW-1:0] r_rx_wptr;
    logic [c_RX_PW-1:0] r_rx_rptr;
    logic [c_RX_CW-1:0] r_rx_count;
    logic               w_rx_full;
    logic               w_rx_empty;
    logic               w_rx_push;
    logic               w_rx_pop;

    assign w_rx_full     = (r_rx_count == c_RX_FULL_CNT);
    assign w_rx_empty    = (r_rx_count == '0);
    assign s_axis_tready = !w_rx_full;
    assign w_rx_push     = s_axis_tvalid && s_axis_tready;
    assign w_rx_pop      = w_rx_rd && !w_rx_empty;

    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= s_axis_tdata;
        end
    end

    // Flush has priority over a same-cycle push: the incoming byte is dropped
    // because the write pointer is forced back to zero.
    always_ff @(posedge clk) begin
        if (rst || w_rx_flush) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + c_RX_PTR_ONE;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + c_RX_PTR_ONE;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + c_RX_CNT_ONE;
                2'b01:   r_rx_count <= r_rx_count - c_RX_CNT_ONE;
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Sticky error flags: a same-cycle set wins over a CTRL clear.
    // ------------------------------------------------------------------------
    logic r_tx_drop;
    logic r_overrun;
    logic r_frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_drop   <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_tx_drop   <= (r_tx_drop   && !w_sticky_clr) || (w_tx_wr && w_tx_full);
            r_overrun   <= (r_overrun   && !w_sticky_clr) || rx_overrun_error;
            r_frame_err <= (r_frame_err && !w_sticky_clr) || rx_frame_error;
        end
    end

    // ------------------------------------------------------------------------
    // Load response: status reflects the state before this cycle's updates.
    // ------------------------------------------------------------------------
    logic [31:0] w_status;
    logic [31:0] w_load_data;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;

    assign w_status = {24'h000000, r_frame_err, r_overrun, r_tx_drop, w_rx_full,
                       tx_busy, !w_rx_empty, w_tx_empty, w_tx_full};

    always_comb begin
        w_load_data = 32'h0000_0000;
        case (w_sel)
            c_REG_RXDATA: begin
                if (!w_rx_empty) begin
                    w_load_data = {1'b1, 23'h000000, r_rx_mem[r_rx_rptr]};
                end
            end
            c_REG_STATUS: w_load_data = w_status;
            default:      w_load_data = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
        end else begin
            r_rsp_valid <= req_valid && !req_we;
            if (req_valid && !req_we) begin
                r_rsp_rdata <= w_load_data;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_mmio
//  Purpose  : Self-checking bench for uart_mmio. Load responses and TX bytes
//             are predicted into queues when stimulus is driven and checked
//             by monitors when the DUT produces them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_mmio;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        tx_busy;
    logic        rx_overrun_error;
    logic        rx_frame_error;

    int n_vec;
    int n_err;

    logic [31:0] rsp_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] rsp_exp;
    logic [7:0]  tx_exp;

    uart_mmio #(.TX_DEPTH(8), .RX_DEPTH(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_we           (req_we),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .tx_busy          (tx_busy),
        .rx_overrun_error (rx_overrun_error),
        .rx_frame_error   (rx_frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitors: compare against the scoreboard on the falling edge.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            n_vec++;
            if (rsp_q.size() == 0) begin
                n_err++;
                $display("FAIL rsp_unexpected got=%08h want=no_response", rsp_rdata);
            end else begin
                rsp_exp = rsp_q.pop_front();
                if (rsp_rdata !== rsp_exp) begin
                    n_err++;
                    $display("FAIL rsp_rdata got=%08h want=%08h", rsp_rdata, rsp_exp);
                end
            end
        end
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            n_vec++;
            if (tx_q.size() == 0) begin
                n_err++;
                $display("FAIL tx_unexpected got=%02h want=no_byte", m_axis_tdata);
            end else begin
                tx_exp = tx_q.pop_front();
                if (m_axis_tdata !== tx_exp) begin
                    n_err++;
                    $display("FAIL tx_byte got=%02h want=%02h", m_axis_tdata, tx_exp);
                end
            end
        end
    end

    task automatic bus_store(input logic [3:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic bus_load(input logic [3:0] a, input logic [31:0] exp);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        rsp_q.push_back(exp);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++;
        if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0 ||
            rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || m_axis_tdata !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs got tready=%b tvalid=%b rspv=%b rdata=%08h tdata=%02h want 1 0 0 0 0",
                     s_axis_tready, m_axis_tvalid, rsp_valid, rsp_rdata, m_axis_tdata);
        end
        bus_load(4'h8, 32'h0000_0002);
    endtask

    task automatic test_tx_fill_drain();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus_store(4'h0, 32'h41 + i);
            tx_q.push_back(8'(8'h41 + i));
        end
        bus_store(4'h0, 32'h49);
        // Full with drop set; tx_empty is clear while full.
        bus_load(4'h8, 32'h0000_0021);
        bus_load(4'h0, 32'h0000_0000);
        m_axis_tready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_vec++;
        if (tx_q.size() != 0 || m_axis_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL tx_drain got left=%0d tvalid=%b want left=0 tvalid=0",
                     tx_q.size(), m_axis_tvalid);
        end
        bus_store(4'hC, 32'h1);
        bus_load(4'h8, 32'h0000_0002);
    endtask

    task automatic test_rx_basic();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h5A;
        @(posedge clk); #1;
        s_axis_tdata  = 8'h3C;
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        bus_load(4'h4, 32'h8000_005A);
        bus_load(4'h4, 32'h8000_003C);
        bus_load(4'h4, 32'h0000_0000);
        bus_store(4'h4, 32'hFF);
        bus_load(4'h8, 32'h0000_0002);
    endtask

    task automatic test_rx_full();
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_axis_tdata = 8'(8'h10 + i);
            @(posedge clk); #1;
        end
        s_axis_tdata = 8'h18;
        n_vec++;
        if (s_axis_tready !== 1'b0) begin
            n_err++;
            $display("FAIL rx_full_tready got=%b want=0", s_axis_tready);
        end
        @(posedge clk); #1;
        bus_load(4'h4, 32'h8000_0010);
        n_vec++;
        if (s_axis_tready !== 1'b1) begin
            n_err++;
            $display("FAIL rx_after_pop_tready got=%b want=1", s_axis_tready);
        end
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        n_vec++;
        if (s_axis_tready !== 1'b0) begin
            n_err++;
            $display("FAIL rx_refill_tready got=%b want=0", s_axis_tready);
        end
        bus_load(4'h8, 32'h0000_0016);
        for (int i = 1; i < 9; i++) begin
            bus_load(4'h4, 32'h8000_0010 + i);
        end
        bus_load(4'h4, 32'h0000_0000);
    endtask

    task automatic test_rx_flush();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h77;
        @(posedge clk); #1;
        s_axis_tdata  = 8'h78;
        @(posedge clk); #1;
        s_axis_tdata  = 8'h79;
        bus_store(4'hC, 32'h2);
        s_axis_tvalid = 1'b0;
        bus_load(4'h8, 32'h0000_0002);
        bus_load(4'h4, 32'h0000_0000);
    endtask

    task automatic test_sticky();
        rx_frame_error   = 1'b1;
        rx_overrun_error = 1'b1;
        @(posedge clk); #1;
        rx_frame_error   = 1'b0;
        rx_overrun_error = 1'b0;
        bus_load(4'h8, 32'h0000_00C2);
        bus_store(4'hC, 32'h1);
        bus_load(4'h8, 32'h0000_0002);
        rx_frame_error = 1'b1;
        bus_store(4'hC, 32'h1);
        rx_frame_error = 1'b0;
        bus_load(4'h8, 32'h0000_0082);
        tx_busy = 1'b1;
        bus_load(4'h8, 32'h0000_008A);
        tx_busy = 1'b0;
        bus_store(4'hC, 32'h1);
        bus_load(4'h8, 32'h0000_0002);
    endtask

    task automatic test_back_to_back();
        // Stream bytes in with the sink ready: each byte leaves the cycle after.
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_store(4'h0, 32'hA0 + i);
            tx_q.push_back(8'(8'hA0 + i));
        end
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (tx_q.size() != 0 || m_axis_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_drain got left=%0d tvalid=%b want left=0 tvalid=0",
                     tx_q.size(), m_axis_tvalid);
        end
    endtask

    task automatic test_mid_reset();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_store(4'h0, 32'h01 + i);
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h55;
        @(posedge clk); #1;
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        n_vec++;
        if (m_axis_tvalid !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_tvalid got=%b want=1", m_axis_tvalid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1 || rsp_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL post_reset got tvalid=%b tready=%b rdata=%08h want 0 1 00000000",
                     m_axis_tvalid, s_axis_tready, rsp_rdata);
        end
        bus_load(4'h8, 32'h0000_0002);
        bus_load(4'h4, 32'h0000_0000);
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec            = 0;
        n_err            = 0;
        rst              = 1'b1;
        req_valid        = 1'b0;
        req_we           = 1'b0;
        req_addr         = 4'h0;
        req_wdata        = 32'h0;
        m_axis_tready    = 1'b0;
        s_axis_tdata     = 8'h00;
        s_axis_tvalid    = 1'b0;
        tx_busy          = 1'b0;
        rx_overrun_error = 1'b0;
        rx_frame_error   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        test_reset();
        test_tx_fill_drain();
        test_rx_basic();
        test_rx_full();
        test_rx_flush();
        test_sticky();
        test_back_to_back();
        test_mid_reset();

        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (rsp_q.size() != 0 || tx_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_items got rsp=%0d tx=%0d want rsp=0 tx=0",
                     rsp_q.size(), tx_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
